fft_peak_picker: RTL
====================

# fft_peak_picker

Consumes the 32-bit AXI-Stream output of `fft` (one complex bin per beat, `last` on bin NFFT-1) and reports the positive-frequency bin with the largest magnitude-squared, once per frame. It sits directly downstream of `fft` and drives `fft_out_ready`, making it the receiving end of that stream. Its output feeds the note-mapping logic as a bin index plus magnitude.

## Interface
- `NFFT`, 4096: frame length in beats; power of two.
- `MIN_BIN`, 1: lowest bin eligible for the peak; 1 excludes DC.
- `clk_in` in 1: system clock (100 MHz).
- `rst_in` in 1: reset, asynchronous, active-low.
- `fft_out_valid` in 1: beat valid from `fft`.
- `fft_out_ready` out 1: this block accepts a beat.
- `fft_out_data` in 32: [15:0] real, [31:16] imaginary, both signed two's complement.
- `fft_out_last` in 1: final beat of frame.
- `peak_valid` out 1: one-cycle pulse; peak outputs are updated.
- `peak_bin` out log2(NFFT): winning bin index.
- `peak_mag` out 32: re²+im² of the winning bin, unsigned.
- `frame_err` out 1: frame-length error flag, valid with `peak_valid`.

## Operation
- A beat is accepted on a cycle with `fft_out_valid && fft_out_ready`. The beat counter `bin_cnt` (log2(NFFT) bits) assigns the bin index and increments per accepted beat.
- Magnitude is re²+im², computed exactly: each square ≤ 2^30, sum ≤ 2^31, so 32 bits unsigned with no truncation.
- Eligible bins satisfy MIN_BIN ≤ bin < NFFT/2. Other bins are counted but never compared.
- Best tracking:
  - The first eligible bin of a frame unconditionally loads `best_mag`/`best_bin`.
  - Later eligible bins replace the best only if their mag is strictly greater, so the lowest index wins ties.
  - An all-zero frame reports bin MIN_BIN, mag 0.
- `frame_err` is set for the frame if either of these occurs:
  - `last` arrives on an accepted beat with `bin_cnt` ≠ NFFT-1.
  - `bin_cnt` = NFFT-1 is accepted without `last`.
- A frame ends on an accepted `last` beat or on the NFFT-th beat, whichever comes first. A missing `last` does not stall the block.
- State machine:
  - RECV: ready=1. On end-of-frame beat → DRAIN.
  - DRAIN: ready=0, 3 cycles fixed (down-counter) → REPORT.
  - REPORT: ready=0. Load output registers, pulse `peak_valid`, clear `bin_cnt`/best/err. → RECV.
- Outputs `peak_bin`, `peak_mag` and `frame_err` hold their values until the next REPORT.
- Reset (any time, including mid-frame or in DRAIN) forces state RECV, clears the pipeline and counters, and discards the partial frame. No `peak_valid` is produced for it.

## Timing
- Reset values:
  - `fft_out_ready`=0 while `rst_in`=0, and 1 on the first cycle after release.
  - `peak_valid`=0, `peak_bin`=0, `peak_mag`=0, `frame_err`=0.
- Magnitude pipeline: beat at cycle t gives squares registered at t+1, sum at t+2, best updated at the end of t+2.
- If the end-of-frame beat is accepted at cycle T:
  - `fft_out_ready` is low at T+1…T+4.
  - `peak_valid` is high at T+4 only, with outputs valid from T+4.
  - `fft_out_ready` returns high at T+5.
- Back-to-back frames therefore lose 4 cycles. `fft` must tolerate backpressure, which AXI-S requires.
- Gaps in `fft_out_valid` are legal anywhere. The pipeline advances on valid-tagged stages only, and bin indices stay contiguous.
- `fft_out_data`/`last` are ignored when not accepted.

## Structure
- Package `fft_pkg`:
  - `NFFT_DEFAULT`, `BIN_W` = $clog2(NFFT).
  - typedef `fft_beat_t` (packed struct im/re, signed 16 each).
  - typedef `mag_t` (logic [31:0]).
  - enum `peak_state_t` {RECV, DRAIN, REPORT}.
- Sub-module `fft_mag_sq`: 2-stage pipelined re²+im² with valid and bin-index sideband, latency 2, no stall input.
- Top: FSM, beat counter, compare/best registers, output registers.

## Test plan
- Full 4096-beat frame, all zero except bin 300 = (re 1000, im 0) → `peak_bin`=300, `peak_mag`=1000000, `frame_err`=0, `peak_valid` exactly 4 cycles after the `last` handshake.
- Bins 100 and 200 both (re 3, im 4), rest zero → `peak_bin`=100, `peak_mag`=25.
- Bin 3000 = (re 20000, im 0), bin 50 = (re 10, im 0), bin 0 = (re 30000, im 0) → `peak_bin`=50, `peak_mag`=100; upper half and DC are excluded.
- Bin 7 = (re -32768, im -32768) → `peak_mag`=2147483648, `peak_bin`=7.
- `last` on beat index 9 → `peak_valid` with `frame_err`=1. The next full frame reports `frame_err`=0 and starts at bin 0.
- Random `fft_out_valid` gaps (~30% idle) on frame 1, then assert `rst_in`=0 for 2 cycles mid-frame 2 → frame 1 results identical to the no-gap run, no `peak_valid` for frame 2, and a clean frame 3 reports correctly.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT peak picker.
package fft_pkg;

    localparam int NFFT_DEFAULT = 4096;
    localparam int BIN_W        = $clog2(NFFT_DEFAULT);
    // DRAIN length; the last beat clears the magnitude pipeline and the
    // best register inside this window.
    localparam int DRAIN_CYCLES = 3;

    // One FFT bin as carried on the AXI-Stream data bus.
    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } fft_beat_t;

    typedef logic [31:0] mag_t;

    typedef enum logic [1:0] {RECV, DRAIN, REPORT} peak_state_t;

    // Exact square of a signed 16-bit value; the largest result is 2^30.
    function automatic mag_t sq16(input logic signed [15:0] x);
        logic signed [31:0] xe;
        logic signed [31:0] p;
        xe = 32'(x);
        p  = xe * xe;
        return $unsigned(p);
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage re^2 + im^2 pipeline with valid and bin-index sideband.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int BW = BIN_W
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          beat_vld,
    input  fft_beat_t     beat,
    input  logic [BW-1:0] beat_bin,
    output logic          mag_vld,
    output mag_t          mag,
    output logic [BW-1:0] mag_bin
);

    localparam int STAGES = 2;

    // Stage k is occupied when vld_pipe[k] is set; stage 0 is the input.
    logic [STAGES:1] vld_pipe;
    mag_t            re_sq;
    mag_t            im_sq;
    logic [BW-1:0]   bin_s1;

    // Valid shift register; data stages only load on a valid tag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) vld_pipe <= '0;
        else         vld_pipe <= {vld_pipe[STAGES-1:1], beat_vld};
    end

    // Stage 1: the two squares and the bin index.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            re_sq  <= '0;
            im_sq  <= '0;
            bin_s1 <= '0;
        end else if (beat_vld) begin
            re_sq  <= sq16(beat.re);
            im_sq  <= sq16(beat.im);
            bin_s1 <= beat_bin;
        end
    end

    // Stage 2: the sum, at most 2^31, so no carry out of 32 bits.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mag     <= '0;
            mag_bin <= '0;
        end else if (vld_pipe[1]) begin
            mag     <= re_sq + im_sq;
            mag_bin <= bin_s1;
        end
    end

    assign mag_vld = vld_pipe[STAGES];

endmodule

// File: rtl/fft_peak_picker.sv
// Per-frame argmax of |X[k]|^2 over positive-frequency bins of the FFT stream.
module fft_peak_picker
    import fft_pkg::*;
#(
    parameter  int NFFT    = NFFT_DEFAULT,
    parameter  int MIN_BIN = 1,
    localparam int BW      = $clog2(NFFT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          fft_out_valid,
    output logic          fft_out_ready,
    input  logic [31:0]   fft_out_data,
    input  logic          fft_out_last,
    output logic          peak_valid,
    output logic [BW-1:0] peak_bin,
    output logic [31:0]   peak_mag,
    output logic          frame_err
);

    localparam logic [BW-1:0] LAST_BIN = BW'(NFFT - 1);
    localparam logic [BW-1:0] MIN_L    = BW'(MIN_BIN);
    localparam logic [1:0]    DRAIN_LD = 2'(DRAIN_CYCLES - 1);

    peak_state_t   state;
    peak_state_t   state_nxt;
    logic [1:0]    drain_cnt;
    logic [BW-1:0] bin_cnt;
    logic          err_acc;
    fft_beat_t     beat;
    logic          accept;
    logic          at_end;
    logic          eof;
    logic          report_ld;

    logic          m_vld;
    mag_t          m_mag;
    logic [BW-1:0] m_bin;
    logic          eligible;

    mag_t          best_mag;
    logic [BW-1:0] best_bin;
    logic          best_seen;

    assign beat      = fft_beat_t'(fft_out_data);
    assign accept    = fft_out_valid && fft_out_ready;
    assign at_end    = (bin_cnt == LAST_BIN);
    // A frame ends on last or on the NFFT-th beat, whichever is first.
    assign eof       = accept && (fft_out_last || at_end);
    // Final DRAIN cycle: outputs load here so they are visible with peak_valid.
    assign report_ld = (state == DRAIN) && (drain_cnt == '0);

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= RECV;
        else         state <= state_nxt;
    end

    // Next state and ready; ready is held low while reset is asserted.
    always_comb begin
        state_nxt     = state;
        fft_out_ready = 1'b0;
        case (state)
            RECV: begin
                fft_out_ready = rst_in;
                if (eof) state_nxt = DRAIN;
            end
            DRAIN:   if (drain_cnt == '0) state_nxt = REPORT;
            REPORT:  state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    // Fixed-length drain down-counter, loaded on the end-of-frame beat.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                            drain_cnt <= '0;
        else if (state == RECV && eof)          drain_cnt <= DRAIN_LD;
        else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 2'd1;
    end

    // Beat counter: bin index of the next accepted beat.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)               bin_cnt <= '0;
        else if (state == REPORT)  bin_cnt <= '0;
        else if (accept)           bin_cnt <= bin_cnt + BW'(1);
    end

    // Sticky frame-length error: last on the wrong beat, or a missing last.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                               err_acc <= 1'b0;
        else if (state == REPORT)                  err_acc <= 1'b0;
        else if (accept && (fft_out_last != at_end)) err_acc <= 1'b1;
    end

    fft_mag_sq #(.BW(BW)) u_mag_sq (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .beat_vld (accept),
        .beat     (beat),
        .beat_bin (bin_cnt),
        .mag_vld  (m_vld),
        .mag      (m_mag),
        .mag_bin  (m_bin)
    );

    // Eligible: MIN_BIN <= bin < NFFT/2 (top index bit clear).
    assign eligible = (m_bin >= MIN_L) && !m_bin[BW-1];

    // Best tracker; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            best_mag  <= '0;
            best_bin  <= '0;
            best_seen <= 1'b0;
        end else if (state == REPORT) begin
            best_mag  <= '0;
            best_bin  <= '0;
            best_seen <= 1'b0;
        end else if (m_vld && eligible && (!best_seen || m_mag > best_mag)) begin
            best_mag  <= m_mag;
            best_bin  <= m_bin;
            best_seen <= 1'b1;
        end
    end

    // Output registers, held until the next report.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            frame_err  <= 1'b0;
        end else begin
            peak_valid <= report_ld;
            if (report_ld) begin
                peak_bin  <= best_bin;
                peak_mag  <= best_mag;
                frame_err <= err_acc;
            end
        end
    end

endmodule
